count_ctrl: RTL and testbench
=============================

# count_ctrl

Run controller for the JK-based 4-bit `counter` block. On a start request it clears the counter and enables it for a programmed number of full 16-count passes, using the counter's `rcol` ripple carry to detect pass boundaries. It counts completed passes and then parks the counter. It reports completion through a done/ack handshake. It sits between the control logic that issues start/abort and one `counter` instance.

## Interface
- No parameters; counter width fixed at 4 bits, pass field 4 bits.
- `clk` in 1: single clock, rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `start` in 1: run request, sampled only in IDLE.
- `passes` in 4: pass count latched on start; 0 means 16 passes.
- `abort` in 1: cancel run, honoured in CLEAR, RUN, DONE.
- `ack` in 1: completion acknowledge, honoured only in DONE.
- `rcol` in 1: counter ripple carry out; high in the cycle the counter is at 15 with `in_EN` high.
- `cnt_en` out 1: drives counter `in_EN`.
- `cnt_clr` out 1: drives counter `clr`.
- `busy` out 1: high in CLEAR and RUN.
- `done` out 1: high in DONE.
- `pass_cnt` out 4: completed passes of the current/last run.

## Operation
- States: IDLE, CLEAR, RUN, DONE; all outputs are decoded from state registers only (no input-to-output combinational paths).
- IDLE: `cnt_clr`=1, `cnt_en`=0. `start`=1 → CLEAR; latch `passes` into target.
- CLEAR: one cycle; `cnt_clr`=1, `busy`=1, `pass_cnt` ← 0. Next edge → RUN, or IDLE if `abort`.
- RUN: `cnt_en`=1, `cnt_clr`=0, `busy`=1.
  - `rcol`=1 at an edge: `pass_cnt` ← `pass_cnt`+1 (mod 16).
  - If (`pass_cnt`+1) mod 16 == target → DONE.
- DONE: `done`=1, `cnt_en`=0, `cnt_clr`=0. The counter is left at 0 after its final wrap. `ack` or `abort` → IDLE.
- Priority:
  - `abort` beats `rcol` in RUN; the pass is not counted.
  - `abort` beats `ack` in DONE; both lead to IDLE.
- Ignored inputs:
  - `start` outside IDLE.
  - `ack` outside DONE.
  - `abort` in IDLE.
- `pass_cnt` holds its value through DONE and IDLE until the next CLEAR.
- Target 0: the compare matches at the wrap 15→0, giving exactly 16 passes.
- `rcol` in any state other than RUN is ignored.

## Timing
- Reset values: state IDLE, `cnt_en`=0, `cnt_clr`=1, `busy`=0, `done`=0, `pass_cnt`=0, target=0. Reset takes effect immediately, including mid-run.
- Start sampled at edge E:
  - CLEAR during cycle E+1.
  - RUN from edge E+2, with `cnt_en` high.
- The first `rcol` is high in the 16th RUN cycle.
- N passes (N=1..16): `cnt_en` high for exactly 16·N cycles. `done` rises at edge E+2+16·N, the same edge at which `cnt_en` falls.
- Throughput: `ack` at edge A gives IDLE at A+1. A new `start` is accepted at edge A+1 at the earliest.

## Configuration
- `COUNT_CTRL_PAUSE_EN` defined:
  - Adds input port `hold` (1 bit).
  - In RUN, `cnt_en` = !`hold`; the state and the 16·N enabled-cycle budget are preserved.
  - Latency grows by the number of held RUN cycles.
  - `hold` has no effect outside RUN.
- Not defined: no `hold` port; `cnt_en` = (state==RUN).

## Test plan
- Reset, then `start` with `passes`=2, `counter` instance attached:
  - `cnt_clr` high through CLEAR.
  - `cnt_en` high for exactly 32 cycles.
  - `pass_cnt` goes 1 then 2.
  - `done` rises at E+34 and holds until `ack`, then IDLE.
- `passes`=0: `cnt_en` high for 256 cycles; `pass_cnt` reads 0 in DONE after wrapping; `done` at E+258.
- `abort` during RUN in the same cycle as `rcol`=1:
  - `pass_cnt` is unchanged.
  - Next state is IDLE, with `cnt_clr`=1 and `cnt_en`=0.
  - `done` never asserts.
- `start` pulsed during RUN and `ack` pulsed during RUN: both have no effect, and the run completes at the original cycle count.
- `clr` asserted mid-RUN, asynchronously between edges: all outputs reach reset values before the next edge; the next `start` runs normally.
- With `COUNT_CTRL_PAUSE_EN`, `passes`=1, `hold` high for 5 RUN cycles:
  - `cnt_en` low for those cycles.
  - `done` at E+23.
  - 16 enabled cycles in total.

Source files
------------

// File: rtl/count_ctrl.sv
// Run controller for a 4-bit ripple-carry counter: clears it, enables it for N full
// passes, then parks it. Optional COUNT_CTRL_PAUSE_EN adds a `hold` input that stalls RUN.
module count_ctrl (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [3:0] passes,
   input  logic       abort,
   input  logic       ack,
   input  logic       rcol,
`ifdef COUNT_CTRL_PAUSE_EN
   input  logic       hold,
`endif
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       busy,
   output logic       done,
   output logic [3:0] pass_cnt
);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

   state_t     state, state_nx;
   logic [3:0] target, target_nx;
   logic [3:0] pass_nx;
   logic [3:0] pass_inc;

   assign pass_inc = pass_cnt + 4'd1;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state    <= IDLE;
         target   <= 4'd0;
         pass_cnt <= 4'd0;
      end else begin
         state    <= state_nx;
         target   <= target_nx;
         pass_cnt <= pass_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      target_nx = target;
      pass_nx   = pass_cnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx  = CLEAR;
               target_nx = passes;
            end
         end
         CLEAR: begin
            pass_nx  = 4'd0;
            state_nx = abort ? IDLE : RUN;
         end
         RUN: begin
            // abort wins over a coincident carry: the pass is dropped
            if (abort) begin
               state_nx = IDLE;
            end else if (rcol) begin
               pass_nx = pass_inc;
               // target 0 matches on the 15->0 wrap, i.e. 16 passes
               if (pass_inc == target) state_nx = DONE;
            end
         end
         DONE: begin
            if (abort || ack) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign cnt_clr = (state == IDLE) || (state == CLEAR);
   assign busy    = (state == CLEAR) || (state == RUN);
   assign done    = (state == DONE);
`ifdef COUNT_CTRL_PAUSE_EN
   assign cnt_en  = (state == RUN) && !hold;
`else
   assign cnt_en  = (state == RUN);
`endif

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl with a behavioural 4-bit counter attached.
// Edge E is the edge that samples start; "edge E+j" is observed at the negedge just before it.
module tb_count_ctrl;

   logic       clk, clr, start, abort, ack, hold;
   logic [3:0] passes;
   logic       cnt_en, cnt_clr, busy, done, rcol;
   logic [3:0] pass_cnt;
   logic [3:0] q;
   int         tests, fails;
   int         pcs[$];
   int         en_cnt, done_j, ab_j;

   count_ctrl dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .passes   (passes),
      .abort    (abort),
      .ack      (ack),
      .rcol     (rcol),
`ifdef COUNT_CTRL_PAUSE_EN
      .hold     (hold),
`endif
      .cnt_en   (cnt_en),
      .cnt_clr  (cnt_clr),
      .busy     (busy),
      .done     (done),
      .pass_cnt (pass_cnt)
   );

   // counter model: async clear, ripple carry at 15 while enabled
   always_ff @(posedge clk or posedge cnt_clr) begin
      if (cnt_clr)     q <= 4'd0;
      else if (cnt_en) q <= q + 4'd1;
   end
   assign rcol = cnt_en && (q == 4'hf);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // kind: 0 plain, 1 abort on first rcol, 2 start+ack pulse at inj_j,
   //       3 hold for 5 samples from inj_j, 4 abort during CLEAR
   task automatic run(input logic [3:0] p, input int kind, input int inj_j,
                      output int en_o, output int done_o, output int ab_o);
      int n, budget;
      int last_pc;
      n = (p == 4'd0) ? 16 : int'(p);
      budget = 16 * n + 40;
      en_o = 0; done_o = -1; ab_o = -1; last_pc = 0;
      pcs.delete();
      @(negedge clk); start = 1'b1; passes = p;
      @(posedge clk); #1 start = 1'b0;
      for (int j = 1; j <= budget; j++) begin
         @(negedge clk);
         if (j == 1) begin
            chk("clear_busy", busy, 1);
            chk("clear_cnt_clr", cnt_clr, 1);
            chk("clear_en", cnt_en, 0);
         end
         if (ab_o >= 0) begin
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_cnt_clr", cnt_clr, 1);
            chk("abort_en", cnt_en, 0);
            chk("abort_pass_cnt", pass_cnt, 0);
            break;
         end
         if (cnt_en) en_o++;
         if (j >= 2 && int'(pass_cnt) != last_pc) begin
            pcs.push_back(int'(pass_cnt));
            last_pc = int'(pass_cnt);
         end
         if (done) begin
            done_o = j;
            break;
         end
         if ((kind == 1 && rcol) || (kind == 4 && j == 1)) begin
            abort = 1'b1;
            ab_o  = j;
         end
         if (kind == 2) begin
            start = (j == inj_j);
            ack   = (j == inj_j);
         end
         if (kind == 3) hold = (j + 1 >= inj_j) && (j + 1 < inj_j + 5);
      end
      start = 1'b0; ack = 1'b0; hold = 1'b0; abort = 1'b0;
   endtask

   task automatic do_ack(input logic with_abort);
      @(negedge clk); ack = 1'b1; abort = with_abort;
      @(negedge clk); ack = 1'b0; abort = 1'b0;
      chk("ack_done", done, 0);
      chk("ack_busy", busy, 0);
      chk("ack_cnt_clr", cnt_clr, 1);
   endtask

   initial begin
      tests = 0; fails = 0;
      clr = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0; hold = 1'b0; passes = 4'd0;
      #3;
      chk("rst_en", cnt_en, 0);
      chk("rst_cnt_clr", cnt_clr, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass_cnt", pass_cnt, 0);
      #9 clr = 1'b0;

      // two passes
      run(4'd2, 0, 0, en_cnt, done_j, ab_j);
      chk("p2_en_cycles", en_cnt, 32);
      chk("p2_done_edge", done_j, 34);
      chk("p2_pc_changes", pcs.size(), 2);
      chk("p2_pc_first", pcs[0], 1);
      chk("p2_pc_second", pcs[1], 2);
      chk("p2_counter_parked", q, 0);
      chk("p2_done_en", cnt_en, 0);
      chk("p2_done_cnt_clr", cnt_clr, 0);
      repeat (3) @(negedge clk);
      chk("p2_done_hold", done, 1);
      do_ack(1'b0);
      chk("p2_pc_after_ack", pass_cnt, 2);

      // passes=0 means 16 passes; ack and abort together in DONE
      run(4'd0, 0, 0, en_cnt, done_j, ab_j);
      chk("p0_en_cycles", en_cnt, 256);
      chk("p0_done_edge", done_j, 258);
      chk("p0_pc_changes", pcs.size(), 16);
      chk("p0_pass_cnt", pass_cnt, 0);
      do_ack(1'b1);

      // abort coincident with rcol
      run(4'd2, 1, 0, en_cnt, done_j, ab_j);
      chk("ab_rcol_edge", ab_j, 17);
      chk("ab_no_done", done_j, -1);
      repeat (4) @(negedge clk);
      chk("ab_done_stays_low", done, 0);
      chk("ab_stays_idle", cnt_clr, 1);

      // abort during CLEAR
      run(4'd2, 4, 0, en_cnt, done_j, ab_j);
      chk("abclr_edge", ab_j, 1);
      chk("abclr_no_run", en_cnt, 0);

      // start and ack pulsed mid-run are ignored
      run(4'd1, 2, 5, en_cnt, done_j, ab_j);
      chk("ign_en_cycles", en_cnt, 16);
      chk("ign_done_edge", done_j, 18);
      chk("ign_pass_cnt", pass_cnt, 1);
      do_ack(1'b0);

      // asynchronous reset mid-run
      @(negedge clk); start = 1'b1; passes = 4'd3;
      @(posedge clk); #1 start = 1'b0;
      repeat (40) @(negedge clk);
      chk("mid_pre_pass_cnt", pass_cnt, 2);
      #2 clr = 1'b1;
      #1;
      chk("mid_rst_en", cnt_en, 0);
      chk("mid_rst_cnt_clr", cnt_clr, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_pass_cnt", pass_cnt, 0);
      chk("mid_rst_counter", q, 0);
      #1 clr = 1'b0;
      run(4'd1, 0, 0, en_cnt, done_j, ab_j);
      chk("post_rst_en_cycles", en_cnt, 16);
      chk("post_rst_done_edge", done_j, 18);
      do_ack(1'b0);

`ifdef COUNT_CTRL_PAUSE_EN
      // five held RUN cycles stretch the run by five edges
      run(4'd1, 3, 4, en_cnt, done_j, ab_j);
      chk("hold_en_cycles", en_cnt, 16);
      chk("hold_done_edge", done_j, 23);
      chk("hold_pass_cnt", pass_cnt, 1);
      do_ack(1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
